uart_fifo_ctrl: RTL
===================

// Module: uart_fifo_ctrl
// PURPOSE
// Configurable full-duplex UART peripheral for the MCU bus. It has 16x-oversampled RX,
// selectable parity and stop bits, and TX/RX FIFOs of depth FIFO_DEPTH.
// It provides CTS/RTS flow control and sticky error flags.
// The bus-side register block drives it directly through FIFO push/pop strobes.
// PARAMETERS
// DATA_BITS   8   data bits per frame, legal range 5..8, sent LSB first
// FIFO_DEPTH  4   entries per FIFO; must be a power of 2 and >= 2
// BAUD_W      12  width of baud_div
// PORTS
// clk         in   1          clock
// rst_n       in   1          reset; synchronous, active-low
// baud_div    in   BAUD_W     oversample tick period = baud_div+1 clk cycles
// parity_en   in   1          1: a parity bit follows the data bits
// parity_odd  in   1          1: odd parity; 0: even parity
// two_stop    in   1          1: TX sends 2 stop bits (RX checks only the first)
// tx_wr       in   1          push tx_data into the TX FIFO
// tx_data     in   DATA_BITS  TX word
// tx_full     out  1          TX FIFO full
// tx_idle     out  1          TX FIFO empty and TX FSM in IDLE
// tx          out  1          serial out; idles high
// cts_n       in   1          0: peer permits transmission
// rx          in   1          serial in; asynchronous
// rx_rd       in   1          pop the head of the RX FIFO
// rx_data     out  DATA_BITS  RX FIFO head (first-word fall-through); 0 when empty
// rx_valid    out  1          RX FIFO not empty
// rts         out  1          1: RX FIFO full, peer must hold off
// rx_overrun  out  1          sticky: a received word was dropped
// parity_err  out  1          sticky: parity mismatch
// frame_err   out  1          sticky: first stop bit sampled as 0
// err_clear   in   1          clears all three sticky flags
// BEHAVIOUR
// - Reset values: tx=1, tx_full=0, tx_idle=1, rx_valid=0, rx_data=0, rts=0, all flags 0.
//   Reset also clears the FIFOs, the FSMs and the counters. The rx synchroniser resets to 1.
// - Tick generator: free-running counter 0..baud_div. tick=1 for the cycle in which count==baud_div.
//   The counter then wraps to 0. baud_div=0 gives a tick every cycle. One bit lasts 16 ticks.
// - TX FSM states: IDLE, START, DATA, PARITY, STOP.
//   - IDLE->START when the TX FIFO is non-empty and cts_n==0. The FIFO pops in that same cycle.
//   - parity_en, parity_odd and two_stop are latched at frame start.
//   - cts_n is sampled only at frame start. Deasserting it mid-frame does not abort the frame.
//   - Parity bit = XOR of the data bits, XOR parity_odd.
//   - STOP lasts 16 or 32 ticks, then the FSM goes to IDLE.
//     If the FIFO is still non-empty, the next START can follow with no idle gap.
//   - tx is registered: tx=0 in START, data bit in DATA, parity bit in PARITY, 1 in IDLE and STOP.
// - RX path:
//   - rx passes through a 2-flop synchroniser.
//   - IDLE->START on a synchronised 1->0 edge. The tick phase counter clears at this point.
//   - After 8 ticks the line is resampled. If it is 1, this is a false start and the FSM returns to IDLE.
//   - Each later bit is sampled after 16 more ticks (mid-bit): DATA bits, PARITY if enabled, then STOP.
//   - At the STOP sample the word is pushed into the RX FIFO even when errors are present.
//   - At the STOP sample, frame_err and/or parity_err are set as applicable. The FSM then returns to IDLE.
//   - A new start requires a fresh 1->0 edge, so a held break low yields only one frame.
// - FIFOs:
//   - Circular buffers with (log2(FIFO_DEPTH)+1)-bit count. Pointers wrap modulo FIFO_DEPTH.
//   - tx_wr while tx_full=1 is ignored.
//   - rx_rd while rx_valid=0 is ignored; pointers do not move.
//   - A TX push and pop in the same cycle are both performed; the count is unchanged.
//   - RX push while full: the word is accepted only if rx_rd pops in the same cycle.
//     Otherwise the word is dropped and rx_overrun is set.
//   - rts = (RX count == FIFO_DEPTH).
// - Sticky flags: err_clear clears them the next cycle.
//   If a new error occurs in the same cycle as err_clear, the flag stays 1.
// - rst_n low mid-frame: TX aborts, tx returns to 1 next cycle, and both FIFO contents are discarded.
// TESTING
// - Reset: apply rst_n=0 for 2 cycles -> tx=1, tx_idle=1, rx_valid=0, rts=0, all flags 0.
// - TX 8N1: baud_div=0, cts_n=0, write 0xA5 -> tx low for 16 clk.
//   Then bits 1,0,1,0,0,1,0,1 for 16 clk each, then high for 16 clk, then tx_idle=1.
// - Loopback: connect tx->rx; parity_en=1, parity_odd=0, two_stop=1; write 0x3C, 0xFF, 0x00.
//   Expect rx_data to read 0x3C, 0xFF, 0x00 in order, with all flags 0.
// - Overrun: FIFO_DEPTH=4, send 5 frames with no rx_rd.
//   Expect rts=1 after the 4th frame, rx_overrun=1 after the 5th, and rx_data=first word.
//   After 4 pops, rx_valid=0.
// - Errors: drive the stop bit as 0 -> frame_err=1 and the word is pushed.
//   Flip the parity bit -> parity_err=1. Pulse err_clear -> both flags return to 0.
// - Flow control and glitch: with cts_n=1 and 2 words queued, tx stays 1 and tx_full=0.
//   A 4-tick low pulse on rx leaves rx_valid=0.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: full-duplex UART with 16x-oversampled RX, optional parity, 1/2 stop bits,
// TX/RX circular FIFOs, CTS/RTS flow control and sticky receive error flags.
module uart_fifo_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BAUD_W-1:0]    baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_full,
  output logic                 tx_idle,
  output logic                 tx,
  input  logic                 cts_n,
  input  logic                 rx,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rts,
  output logic                 rx_overrun,
  output logic                 parity_err,
  output logic                 frame_err,
  input  logic                 err_clear
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---------------- oversample tick generator ----------------
  logic [BAUD_W-1:0] r_baud_cnt;
  logic              w_tick;

  // >= rather than == so a baud_div reduced on the fly cannot strand the counter above it.
  assign w_tick = (r_baud_cnt >= baud_div);

  // NOTE: sequential state uses <= so every register in the edge sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_tx_wptr, r_tx_rptr;
  logic [CNT_W-1:0]     r_tx_count;
  logic                 w_tx_push, w_tx_pop, w_tx_empty;
  logic [DATA_BITS-1:0] w_tx_head;

  assign tx_full    = (r_tx_count == FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_push  = tx_wr && !tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rptr];

  // NOTE: storage arrays are not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_W'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_W'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CNT_W'(1);
        2'b01:   r_tx_count <= r_tx_count - CNT_W'(1);
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t            r_tx_state;
  logic [3:0]           r_tx_tick_cnt;
  logic [BIT_W-1:0]     r_tx_bit_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par_en, r_tx_par_bit, r_tx_two_stop, r_tx;
  logic                 w_tx_bit_end, w_tx_stop_done;

  assign w_tx_bit_end   = w_tick && (r_tx_tick_cnt == 4'd15);
  assign w_tx_stop_done = (r_tx_state == TX_STOP) && w_tx_bit_end &&
                          (!r_tx_two_stop || r_tx_bit_idx[0]);
  // A queued word starts straight out of the last stop bit, so frames run back to back.
  assign w_tx_pop = !w_tx_empty && !cts_n && ((r_tx_state == TX_IDLE) || w_tx_stop_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state    <= TX_IDLE;
      r_tx_tick_cnt <= '0;
      r_tx_bit_idx  <= '0;
      r_tx_shift    <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_two_stop <= 1'b0;
      r_tx          <= 1'b1;
    end else begin
      if (w_tick && (r_tx_state != TX_IDLE)) r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
      if (w_tx_pop) begin
        r_tx_state    <= TX_START;
        r_tx          <= 1'b0;
        r_tx_tick_cnt <= '0;
        r_tx_shift    <= w_tx_head;
        r_tx_par_en   <= parity_en;
        r_tx_par_bit  <= (^w_tx_head) ^ parity_odd;
        r_tx_two_stop <= two_stop;
      end else begin
        case (r_tx_state)
          TX_IDLE: r_tx <= 1'b1;
          TX_START: begin
            if (w_tx_bit_end) begin
              r_tx_state   <= TX_DATA;
              r_tx         <= r_tx_shift[0];
              r_tx_bit_idx <= '0;
            end
          end
          TX_DATA: begin
            if (w_tx_bit_end) begin
              if (r_tx_bit_idx == LAST_BIT) begin
                r_tx_bit_idx <= '0;
                if (r_tx_par_en) begin
                  r_tx_state <= TX_PARITY;
                  r_tx       <= r_tx_par_bit;
                end else begin
                  r_tx_state <= TX_STOP;
                  r_tx       <= 1'b1;
                end
              end else begin
                r_tx_shift   <= r_tx_shift >> 1;
                r_tx         <= r_tx_shift[1];
                r_tx_bit_idx <= r_tx_bit_idx + BIT_W'(1);
              end
            end
          end
          TX_PARITY: begin
            if (w_tx_bit_end) begin
              r_tx_state   <= TX_STOP;
              r_tx         <= 1'b1;
              r_tx_bit_idx <= '0;
            end
          end
          TX_STOP: begin
            if (w_tx_stop_done)    r_tx_state   <= TX_IDLE;
            else if (w_tx_bit_end) r_tx_bit_idx <= r_tx_bit_idx + BIT_W'(1);
          end
          default: begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx      = r_tx;
  assign tx_idle = w_tx_empty && (r_tx_state == TX_IDLE);

  // ---------------- RX synchroniser and FSM ----------------
  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t            r_rx_state;
  logic [3:0]           r_rx_tick_cnt;
  logic [BIT_W-1:0]     r_rx_bit_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_en, r_rx_par_odd, r_rx_par_bad;
  logic                 w_rx_fall, w_rx_mid_bit, w_rx_push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall    = r_rx_prev && !r_rx_sync;
  assign w_rx_mid_bit = w_tick && (r_rx_tick_cnt == 4'd15);
  assign w_rx_push    = (r_rx_state == RX_STOP) && w_rx_mid_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state    <= RX_IDLE;
      r_rx_tick_cnt <= '0;
      r_rx_bit_idx  <= '0;
      r_rx_shift    <= '0;
      r_rx_par_en   <= 1'b0;
      r_rx_par_odd  <= 1'b0;
      r_rx_par_bad  <= 1'b0;
    end else begin
      if (w_tick) r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state    <= RX_START;
            r_rx_tick_cnt <= '0;
            r_rx_bit_idx  <= '0;
            r_rx_par_en   <= parity_en;
            r_rx_par_odd  <= parity_odd;
            r_rx_par_bad  <= 1'b0;
          end
        end
        RX_START: begin
          // Half a bit in: a line back high means the edge was a glitch.
          if (w_tick && (r_rx_tick_cnt == 4'd7)) begin
            r_rx_tick_cnt <= '0;
            r_rx_state    <= r_rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (w_rx_mid_bit) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit_idx == LAST_BIT) r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
            else                          r_rx_bit_idx <= r_rx_bit_idx + BIT_W'(1);
          end
        end
        RX_PARITY: begin
          if (w_rx_mid_bit) begin
            r_rx_par_bad <= (r_rx_sync != ((^r_rx_shift) ^ r_rx_par_odd));
            r_rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_rx_mid_bit) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_rx_wptr, r_rx_rptr;
  logic [CNT_W-1:0]     r_rx_count;
  logic                 w_rx_full, w_rx_pop, w_rx_accept;

  assign w_rx_full   = (r_rx_count == FULL_CNT);
  assign rx_valid    = (r_rx_count != '0);
  assign rts         = w_rx_full;
  assign w_rx_pop    = rx_rd && rx_valid;
  // When full, a simultaneous pop frees the slot the write pointer already points at.
  assign w_rx_accept = w_rx_push && (!w_rx_full || w_rx_pop);
  assign rx_data     = rx_valid ? r_rx_mem[r_rx_rptr] : '0;

  always_ff @(posedge clk) begin
    if (w_rx_accept) r_rx_mem[r_rx_wptr] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_accept) r_rx_wptr <= r_rx_wptr + PTR_W'(1);
      if (w_rx_pop)    r_rx_rptr <= r_rx_rptr + PTR_W'(1);
      case ({w_rx_accept, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CNT_W'(1);
        2'b01:   r_rx_count <= r_rx_count - CNT_W'(1);
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // ---------------- sticky error flags ----------------
  logic r_rx_overrun, r_parity_err, r_frame_err;

  // A new error in the clearing cycle wins over err_clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_overrun <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_overrun <= (r_rx_overrun && !err_clear) || (w_rx_push && w_rx_full && !w_rx_pop);
      r_parity_err <= (r_parity_err && !err_clear) || (w_rx_push && r_rx_par_bad);
      r_frame_err  <= (r_frame_err  && !err_clear) || (w_rx_push && !r_rx_sync);
    end
  end

  assign rx_overrun = r_rx_overrun;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule
